// File: rtl/spi_master_ctrl.sv
// SPI master (CPOL=1, CPHA=1): byte shifter, SCLK divider, chip select and burst sequencing.
// Optional feature macro SPI_CTRL_LOOPBACK_EN adds loopback_i so the rx register samples mosi_o.
module spi_master_ctrl #(
    parameter int HALF_PERIOD = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [7:0] cmd_data_i,
    input  logic       cmd_last_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       busy_o,
    output logic       sclk_o,
    output logic       cs_n_o,
    output logic       mosi_o,
    input  logic       miso_i
`ifdef SPI_CTRL_LOOPBACK_EN
    ,
    input  logic       loopback_i
`endif
);

    // state | meaning
    // IDLE  | CS high; ready once the CS-high guard has expired
    // SETUP | CS low, SCLK high, first bit on MOSI before the first fall
    // LO    | SCLK low half-period
    // HI    | SCLK high half-period
    // GAP   | between burst bytes, CS held low, ready
    // HOLD  | CS low tail after the last byte
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LO, S_HI, S_GAP, S_HOLD} state_t;

    localparam logic [7:0] DIV_RELOAD = 8'(HALF_PERIOD - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_div;
    logic [2:0] r_bit_cnt;
    logic       r_wrap;
    logic       r_last;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_guard;
    logic       w_guard_nxt;
    logic       r_ready;
    logic       r_busy;
    logic       r_sclk;
    logic       r_cs_n;
    logic       w_accept;
    logic       w_div_tc;
    logic       w_rise;
    logic       w_shift;
    logic       w_rx_bit;

    assign w_accept = cmd_valid_i & r_ready;
    assign w_div_tc = (r_div == 8'd0);
    assign w_rise   = (r_state == S_LO) && (w_state_nxt == S_HI);
    assign w_shift  = (r_state == S_HI) && (w_state_nxt == S_LO);

`ifdef SPI_CTRL_LOOPBACK_EN
    assign w_rx_bit = loopback_i ? r_tx[7] : miso_i;
`else
    assign w_rx_bit = miso_i;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_guard_nxt = r_guard;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_SETUP;
                if (w_div_tc) w_guard_nxt = 1'b0;
            end
            S_SETUP: if (w_div_tc) w_state_nxt = S_LO;
            S_LO:    if (w_div_tc) w_state_nxt = S_HI;
            S_HI: begin
                if (w_div_tc) begin
                    if (r_wrap) w_state_nxt = r_last ? S_HOLD : S_GAP;
                    else        w_state_nxt = S_LO;
                end
            end
            S_GAP:   if (w_accept) w_state_nxt = S_LO;
            S_HOLD: begin
                if (w_div_tc) begin
                    w_state_nxt = S_IDLE;
                    w_guard_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_div      <= DIV_RELOAD;
            r_bit_cnt  <= 3'd0;
            r_wrap     <= 1'b0;
            r_last     <= 1'b0;
            r_tx       <= 8'h00;
            r_rx       <= 8'h00;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_guard    <= 1'b1;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_sclk     <= 1'b1;
            r_cs_n     <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_guard <= w_guard_nxt;
            // The divider restarts on every state change; the guard reuses it while in IDLE.
            if (w_state_nxt != r_state) r_div <= DIV_RELOAD;
            else if (!w_div_tc)         r_div <= r_div - 8'd1;

            if (w_accept) begin
                r_tx      <= cmd_data_i;
                r_last    <= cmd_last_i;
                r_bit_cnt <= 3'd0;
                r_wrap    <= 1'b0;
            end else if (w_shift) begin
                r_tx <= {r_tx[6:0], 1'b0};
            end

            if (w_rise) begin
                {r_wrap, r_bit_cnt} <= {1'b0, r_bit_cnt} + 4'd1;
                r_rx <= {r_rx[6:0], w_rx_bit};
                if (r_bit_cnt == 3'd7) r_rx_data <= {r_rx[6:0], w_rx_bit};
            end

            // Outputs are decoded from the next state so they change together with it.
            r_rx_valid <= (r_state == S_HI) && ((w_state_nxt == S_HOLD) || (w_state_nxt == S_GAP));
            r_ready    <= (w_state_nxt == S_GAP) || ((w_state_nxt == S_IDLE) && !w_guard_nxt);
            r_cs_n     <= (w_state_nxt == S_IDLE);
            r_sclk     <= (w_state_nxt != S_LO);
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    assign cmd_ready_o = r_ready;
    assign rx_valid_o  = r_rx_valid;
    assign rx_data_o   = r_rx_data;
    assign busy_o      = r_busy;
    assign sclk_o      = r_sclk;
    assign cs_n_o      = r_cs_n;
    assign mosi_o      = r_tx[7];

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: byte-level slave model, expected queues, timing monitor.
module tb_spi_master_ctrl;
    localparam int HP = 2;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic [7:0] cmd_data_i = 8'h00;
    logic       cmd_last_i = 1'b0;
    logic       rx_valid_o;
    logic [7:0] rx_data_o;
    logic       busy_o;
    logic       sclk_o;
    logic       cs_n_o;
    logic       mosi_o;
    logic       miso_i;
`ifdef SPI_CTRL_LOOPBACK_EN
    logic       loopback_i = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    spi_master_ctrl #(.HALF_PERIOD(HP)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_data_i  (cmd_data_i),
        .cmd_last_i  (cmd_last_i),
        .rx_valid_o  (rx_valid_o),
        .rx_data_o   (rx_data_o),
        .busy_o      (busy_o),
        .sclk_o      (sclk_o),
        .cs_n_o      (cs_n_o),
        .mosi_o      (mosi_o),
        .miso_i      (miso_i)
`ifdef SPI_CTRL_LOOPBACK_EN
        ,
        .loopback_i  (loopback_i)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_mosi_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] slave_q[$];
    int         exp_session_q[$];

    int acc_last = 0;
    int acc_prior = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // The received byte is whatever the slave returned, or our own byte when looped back.
    function automatic logic [7:0] model_rx(input logic [7:0] d, input logic [7:0] s);
`ifdef SPI_CTRL_LOOPBACK_EN
        if (loopback_i) return d;
`endif
        return s;
    endfunction

    task automatic send(input logic [7:0] d, input logic l, input logic [7:0] s,
                        input int gap, input bit abort);
        int n;
        slave_q.push_back(s);
        if (!abort) begin
            exp_mosi_q.push_back(d);
            exp_rx_q.push_back(model_rx(d, s));
        end
        repeat (gap) @(posedge clk_i);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1;
        cmd_data_i  = d;
        cmd_last_i  = l;
        n = 0;
        forever begin
            @(negedge clk_i);
            if (cmd_ready_o === 1'b1) break;
            n++;
            if (n > 2000) break;
        end
        if (n > 2000) fail_now("accept_timeout");
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
    endtask

    // Monitor + slave model, all sampled on the falling system clock.
    int         cyc = 0;
    int         sbit = 0;
    logic [7:0] sbyte = 8'h00;
    logic [7:0] mcap = 8'h00;
    logic       prev_cs = 1'b1;
    logic       prev_sclk = 1'b1;
    int         cs_fall = 0;
    int         sess_len = 0;
    int         sess_rx = 0;
    int         last_rxv = 0;
    bit         first_fall_pend = 0;
    bit         acc_pend = 0;

    initial begin
        miso_i = 1'b0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (prev_cs === 1'b1 && cs_n_o === 1'b0) begin
                cs_fall = cyc;
                sess_len = 0;
                sess_rx = 0;
                first_fall_pend = 1;
            end
            if (cs_n_o === 1'b0) sess_len++;

            if (cs_n_o !== 1'b0) begin
                sbit = 0;
            end else begin
                if (prev_sclk === 1'b1 && sclk_o === 1'b0) begin
                    if (sbit == 0) sbyte = (slave_q.size() != 0) ? slave_q.pop_front() : 8'h00;
                    miso_i = sbyte[7 - sbit];
                end
                if (prev_sclk === 1'b0 && sclk_o === 1'b1) begin
                    mcap = {mcap[6:0], mosi_o};
                    sbit++;
                    if (sbit == 8) begin
                        if (exp_mosi_q.size() != 0) chk("mosi_byte", mcap, exp_mosi_q.pop_front());
                        else fail_now("mosi_unexpected_byte");
                        sbit = 0;
                    end
                end
            end

            if (rx_valid_o === 1'b1) begin
                if (exp_rx_q.size() != 0) chk("rx_data", rx_data_o, exp_rx_q.pop_front());
                else fail_now("rx_valid_unexpected");
                last_rxv = cyc;
                sess_rx++;
            end

            if (first_fall_pend && prev_sclk === 1'b1 && sclk_o === 1'b0) begin
                chk("first_fall_delay", cyc - cs_fall, HP);
                first_fall_pend = 0;
            end

            if (acc_pend) begin
                chk("ready_drop_after_accept", cmd_ready_o, 0);
                chk("cs_low_after_accept", cs_n_o, 0);
                acc_pend = 0;
            end
            if (cmd_valid_i === 1'b1 && cmd_ready_o === 1'b1 && rst_i === 1'b0) begin
                acc_pend = 1;
                acc_prior = acc_last;
                acc_last = cyc;
            end

            if (prev_cs === 1'b0 && cs_n_o === 1'b1 && rst_i === 1'b0) begin
                if (exp_session_q.size() != 0) chk("burst_bytes_per_cs", sess_rx, exp_session_q.pop_front());
                else fail_now("cs_session_unexpected");
                chk("cs_rise_after_last", cyc - last_rxv, HP);
                if (sess_rx == 1) chk("single_cs_low", sess_len, 18 * HP);
            end
            if (rst_i === 1'b1) first_fall_pend = 0;

            prev_cs = cs_n_o;
            prev_sclk = sclk_o;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        logic ps;
        int len;

        // Reset held 3 cycles while a command is being offered.
        cmd_valid_i = 1'b1;
        cmd_data_i  = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            chk("reset_outputs", {cs_n_o, sclk_o, mosi_o, cmd_ready_o, rx_valid_o, busy_o, rx_data_o},
                {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        end
        rst_i = 1'b0;
        cmd_valid_i = 1'b0;
        for (int i = 0; i < HP; i++) begin
            chk("guard_after_reset", cmd_ready_o, 0);
            @(posedge clk_i); #1;
        end
        chk("ready_after_guard", cmd_ready_o, 1);

        // Single byte
        exp_session_q.push_back(1);
        send(8'hA5, 1'b1, 8'h3C, 0, 0);

        // Burst of three with a pause inside GAP
        exp_session_q.push_back(3);
        send(8'h01, 1'b0, 8'h10, 0, 0);
        send(8'h80, 1'b0, 8'h20, 2, 0);
        send(8'hFF, 1'b1, 8'h30, 0, 0);

        // Back-pressure: second byte offered while the first is in flight
        exp_session_q.push_back(1);
        exp_session_q.push_back(1);
        send(8'h11, 1'b1, 8'(($urandom)), 0, 0);
        send(8'h55, 1'b1, 8'(($urandom)), 0, 0);
        chk("backpressure_accept_spacing", acc_last - acc_prior, 19 * HP + 1);

        // Reset after the 3rd rising SCLK
        send(8'h77, 1'b1, 8'h9A, 0, 1);
        rises = 0;
        ps = sclk_o;
        for (int i = 0; i < 500 && rises < 3; i++) begin
            @(negedge clk_i);
            if (ps === 1'b0 && sclk_o === 1'b1) rises++;
            ps = sclk_o;
        end
        if (rises < 3) fail_now("rise_wait_timeout");
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("abort_outputs", {cs_n_o, sclk_o, rx_valid_o, busy_o, rx_data_o},
            {1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        exp_session_q.push_back(1);
        send(8'hC3, 1'b1, 8'h6E, 0, 0);

        // Random bursts
        for (int b = 0; b < 8; b++) begin
            len = int'($urandom_range(1, 4));
            exp_session_q.push_back(len);
            for (int k = 0; k < len; k++)
                send(8'($urandom), (k == len - 1), 8'($urandom), int'($urandom_range(0, 3)), 0);
        end

`ifdef SPI_CTRL_LOOPBACK_EN
        for (int i = 0; i < 2000 && exp_session_q.size() != 0; i++) @(posedge clk_i);
        #1;
        loopback_i = 1'b1;
        exp_session_q.push_back(1);
        send(8'h5A, 1'b1, 8'h00, 0, 0);
        for (int i = 0; i < 2000 && exp_session_q.size() != 0; i++) @(posedge clk_i);
        #1;
        loopback_i = 1'b0;
`endif

        for (int i = 0; i < 4000 && (exp_session_q.size() != 0 || exp_rx_q.size() != 0); i++)
            @(posedge clk_i);
        repeat (5) @(posedge clk_i);
        #1;
        chk("rx_queue_drained", exp_rx_q.size(), 0);
        chk("mosi_queue_drained", exp_mosi_q.size(), 0);
        chk("session_queue_drained", exp_session_q.size(), 0);
        chk("idle_at_end", {cs_n_o, sclk_o, busy_o}, {1'b1, 1'b1, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI master controller that sequences byte transfers for the system's SPI peripherals (slave samples on SCLK rising edge, drives on falling edge, SCLK idle high: CPOL=1, CPHA=1). It contains the 8-bit transmit and receive shift registers and generates their load/shift timing. It also divides the system clock into SCLK and drives chip select. Upstream logic issues bytes over a valid/ready command interface. Bytes can be chained into a multi-byte burst with CS held low throughout.

## Interface
- HALF_PERIOD, 4: clk_i cycles per SCLK half-period; legal range 1..255.
- clk_i  in  1  system clock; all logic on posedge.
- rst_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command byte offered.
- cmd_ready_o  out  1  controller can accept a byte.
- cmd_data_i  in  8  byte to transmit, MSB first.
- cmd_last_i  in  1  deassert CS after this byte.
- rx_valid_o  out  1  one-cycle pulse: rx_data_o holds the received byte.
- rx_data_o  out  8  last received byte; holds until the next pulse.
- busy_o  out  1  high whenever state is not IDLE.
- sclk_o  out  1  SPI clock.
- cs_n_o  out  1  chip select, active low.
- mosi_o  out  1  serial data out (tx shift register MSB).
- miso_i  in  1  serial data in.

## Operation
- Accept = cmd_valid_i & cmd_ready_o. On accept, latch cmd_data_i into the tx register and cmd_last_i into the last flag.
- States:
  - IDLE: cs_n=1, sclk=1, ready=1 once the CS-high guard has expired.
  - SETUP: cs_n=0, sclk=1.
  - LO: sclk=0.
  - HI: sclk=1.
  - GAP: cs_n=0, sclk=1, ready=1.
  - HOLD: cs_n=0, sclk=1.
- IDLE → SETUP on accept.
- SETUP → LO after HALF_PERIOD cycles.
- LO → HI after HALF_PERIOD cycles.
- HI → LO after HALF_PERIOD cycles while bit count < 8.
- After the 8th HI:
  - last=1: → HOLD, then HOLD → IDLE after HALF_PERIOD cycles.
  - last=0: → GAP.
- GAP → LO on accept, with no SETUP. GAP waits indefinitely.
- Transmit:
  - mosi_o always equals tx[7]. The load presents bit 7 before the first falling edge.
  - tx shifts left, 0 filled, on each HI→LO transition (i.e. each falling SCLK after the first).
- Receive:
  - rx shifts in miso_i, MSB first, on each LO→HI transition (rising SCLK).
  - On the 8th rising edge, rx is copied to rx_data_o. rx_valid_o pulses on the first cycle of HOLD or GAP.
- Counters: 3-bit bit counter plus a wrap flag; divider counter is 8 bits and reloads on every state change.
- CS-high guard: after HOLD→IDLE, and after reset, cmd_ready_o stays 0 for HALF_PERIOD cycles.
- Reset mid-transfer:
  - Aborts the transfer.
  - No rx_valid_o pulse.
  - Partially shifted data is discarded; rx_data_o is cleared.

## Timing
- Reset values: cs_n_o=1, sclk_o=1, mosi_o=0, cmd_ready_o=0, rx_valid_o=0, rx_data_o=0x00, busy_o=0, state IDLE.
- All outputs are registered.
- Accept at edge N: cs_n_o=0 from cycle N+1; first sclk_o fall at N+1+HALF_PERIOD.
- Byte duration: 16·HALF_PERIOD cycles from first fall to the end of the 8th HI.
- Single-byte CS-low time: (18·HALF_PERIOD) cycles.
- Burst accept in GAP at edge M: sclk_o falls at M+1.
- cmd_ready_o drops the cycle after accept.
- A cmd_valid_i held while ready=0 is not consumed; cmd_data_i must stay stable until accept.

## Configuration
- SPI_CTRL_LOOPBACK_EN:
  - Defined: adds input loopback_i (1 bit). When loopback_i=1, the rx register samples mosi_o instead of miso_i; all other timing is unchanged.
  - Undefined: the port is absent and rx always samples miso_i.

## Test plan
- Reset: hold rst_i 3 cycles, mid-stream with cmd_valid_i=1 → all outputs at reset values; cmd_ready_o=0 for HALF_PERIOD cycles after release, then 1.
- Single byte: HALF_PERIOD=2, send 0xA5 with last=1, slave model returns 0x3C.
  - mosi at the rising edges reads 1,0,1,0,0,1,0,1.
  - rx_data_o=0x3C with one rx_valid_o pulse.
  - cs_n_o low for exactly 36 cycles.
- Burst: send 0x01, 0x80, 0xFF with last only on 0xFF, slave returns 0x10, 0x20, 0x30.
  - cs_n_o stays low throughout.
  - 3 rx_valid_o pulses with matching data.
  - cs_n_o rises HALF_PERIOD cycles after the 3rd byte.
- Back-pressure: hold cmd_valid_i=1 with 0x55 during the busy period of a 0x11 transfer → no second accept until IDLE/GAP plus guard; 0x55 is then sent intact.
- Reset mid-byte: assert rst_i after the 3rd rising SCLK → next cycle cs_n_o=1 and sclk_o=1, no rx_valid_o; a following 0xC3 transfer is correct.
- Loopback (macro defined, loopback_i=1): send 0x5A with miso_i tied 0 → rx_data_o=0x5A.
